// File: rtl/caesar_vigenere_shift_pipe.sv
// Multi-lane Caesar/Vigenere rotate stage.
// Classifies LANES ASCII bytes per beat. Letters (and digits, when
// DIGITS_EN=1) are rotated by keys taken from a programmable table.
// Two register stages with valid/ready flow control in front and behind.
module caesar_vigenere_shift_pipe #(
  parameter int LANES     = 4,
  parameter int KEY_LEN   = 8,
  parameter bit DIGITS_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*LANES-1:0]         in_data,
  input  logic                       in_last,
  input  logic                       shift_en,
  input  logic                       mode,
  input  logic                       key_we,
  input  logic [$clog2(KEY_LEN)-1:0] key_waddr,
  input  logic [4:0]                 key_wdata,
  input  logic [$clog2(KEY_LEN):0]   key_len_cfg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*LANES-1:0]         out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int AW = $clog2(KEY_LEN);
  localparam logic [1:0] CL_OTHER = 2'd0;
  localparam logic [1:0] CL_UPPER = 2'd1;
  localparam logic [1:0] CL_LOWER = 2'd2;
  localparam logic [1:0] CL_DIGIT = 2'd3;

  function automatic logic [1:0] classify(input logic [7:0] c);
    if (c >= 8'd65 && c <= 8'd90)                return CL_UPPER;
    if (c >= 8'd97 && c <= 8'd122)               return CL_LOWER;
    if (DIGITS_EN && c >= 8'd48 && c <= 8'd57)   return CL_DIGIT;
    return CL_OTHER;
  endfunction

  // Letter rotation modulo 26; key is always below 26.
  function automatic logic [4:0] rot26(input logic [4:0] idx, input logic [4:0] k,
                                       input logic enc);
    logic [5:0] s;
    if (enc) s = {1'b0, idx} + {1'b0, k};
    else     s = {1'b0, idx} + 6'd26 - {1'b0, k};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  // Digit rotation modulo 10 using k mod 10.
  function automatic logic [3:0] rot10(input logic [3:0] d, input logic [4:0] k,
                                       input logic enc);
    logic [4:0] kd;
    logic [4:0] s;
    if (k >= 5'd20)      kd = k - 5'd20;
    else if (k >= 5'd10) kd = k - 5'd10;
    else                 kd = k;
    if (enc) s = {1'b0, d} + kd;
    else     s = {1'b0, d} + 5'd10 - kd;
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  logic [4:0]    key_tab [KEY_LEN];
  logic [AW-1:0] kidx;
  logic [AW:0]   eff_len;

  logic          vld_p1, vld_p2, ld_p2, adv_p1, acc;
  logic [1:0]    cls_p0 [LANES];
  logic [4:0]    idx_p0 [LANES];
  logic [4:0]    key_p0 [LANES];
  logic [AW-1:0] kidx_nxt_p0;

  logic [1:0]    cls_p1 [LANES];
  logic [4:0]    idx_p1 [LANES];
  logic [4:0]    key_p1 [LANES];
  logic [7:0]    byte_p1 [LANES];
  logic          mode_p1, shift_p1, last_p1;
  logic [8*LANES-1:0] rot_p1;

  logic [8*LANES-1:0] data_p2;
  logic          last_p2;

  assign ld_p2     = !vld_p2 || out_ready;
  assign adv_p1    = vld_p1 && ld_p2;
  assign in_ready  = !vld_p1 || ld_p2;
  assign acc       = in_valid && in_ready;
  assign busy      = vld_p1 || vld_p2;
  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_last  = last_p2;

  // Effective key length: 0 reads as 1, oversize values clamp to the table depth.
  always_comb begin
    eff_len = key_len_cfg;
    if (key_len_cfg == '0)                        eff_len = (AW+1)'(1);
    else if (key_len_cfg > (AW+1)'(KEY_LEN))      eff_len = (AW+1)'(KEY_LEN);
  end

  // Key table write; stored values are reduced modulo 26.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_LEN; i++) key_tab[i] <= 5'd0;
    end else if (key_we) begin
      key_tab[key_waddr] <= (key_wdata >= 5'd26) ? key_wdata - 5'd26 : key_wdata;
    end
  end

  // ---- stage 0: classify lanes and pick each alnum lane's key ----
  // Classify lanes and assign consecutive key positions to alnum lanes only.
  always_comb begin
    int cnt;
    int kpos;
    logic [7:0] c;
    cnt  = 0;
    kpos = 0;
    c    = 8'd0;
    for (int i = 0; i < LANES; i++) begin
      c         = in_data[8*i +: 8];
      cls_p0[i] = classify(c);
      case (cls_p0[i])
        CL_UPPER: idx_p0[i] = 5'(c - 8'd65);
        CL_LOWER: idx_p0[i] = 5'(c - 8'd97);
        CL_DIGIT: idx_p0[i] = 5'(c - 8'd48);
        default:  idx_p0[i] = 5'd0;
      endcase
      kpos      = (int'(kidx) + cnt) % int'(eff_len);
      key_p0[i] = key_tab[AW'(kpos)];
      if (cls_p0[i] != CL_OTHER) cnt = cnt + 1;
    end
    kidx_nxt_p0 = AW'((int'(kidx) + cnt) % int'(eff_len));
  end

  // Key index advances by the alnum count when rotating; end of message restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                kidx <= '0;
    else if (acc && in_last) kidx <= '0;
    else if (acc && shift_en) kidx <= kidx_nxt_p0;
  end

  // ---- stage 1: register classification, keys and beat controls ----
  // Stage 1 valid: loads whenever the stage is free or draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Stage 1 payload captured only on an input transfer.
  always_ff @(posedge clk) begin
    if (acc) begin
      cls_p1   <= cls_p0;
      idx_p1   <= idx_p0;
      key_p1   <= key_p0;
      for (int i = 0; i < LANES; i++) byte_p1[i] <= in_data[8*i +: 8];
      mode_p1  <= mode;
      shift_p1 <= shift_en;
      last_p1  <= in_last;
    end
  end

  // Rotate each lane according to its class; bypass when shift is off.
  always_comb begin
    logic [7:0] b;
    b      = 8'd0;
    rot_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      b = byte_p1[i];
      if (shift_p1) begin
        case (cls_p1[i])
          CL_UPPER: b = 8'd65 + {3'b000, rot26(idx_p1[i], key_p1[i], mode_p1)};
          CL_LOWER: b = 8'd97 + {3'b000, rot26(idx_p1[i], key_p1[i], mode_p1)};
          CL_DIGIT: b = 8'd48 + {4'b0000, rot10(idx_p1[i][3:0], key_p1[i], mode_p1)};
          default:  b = byte_p1[i];
        endcase
      end
      rot_p1[8*i +: 8] = b;
    end
  end

  // ---- stage 2: rotated output beat, held while downstream stalls ----
  // Output register loads only when empty or being consumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      last_p2 <= 1'b0;
    end else if (ld_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= rot_p1;
        last_p2 <= last_p1;
      end
    end
  end

endmodule

// File: tb/tb_caesar_vigenere_shift_pipe.sv
// Scoreboard bench for caesar_vigenere_shift_pipe (LANES=4, KEY_LEN=8, DIGITS_EN=1).
// The driver pushes expected beats on acceptance; a monitor pops on each output transfer.
module tb_caesar_vigenere_shift_pipe;
  localparam int LANES = 4;
  localparam int KEY_LEN = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0, shift_en = 1'b0, mode = 1'b0;
  logic [8*LANES-1:0] in_data = '0, out_data;
  logic key_we = 1'b0;
  logic [AW-1:0] key_waddr = '0;
  logic [4:0] key_wdata = '0;
  logic [AW:0] key_len_cfg = 4'd1;
  logic out_valid, out_ready = 1'b1, out_last, busy;

  caesar_vigenere_shift_pipe #(.LANES(LANES), .KEY_LEN(KEY_LEN), .DIGITS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .shift_en(shift_en), .mode(mode), .key_we(key_we),
    .key_waddr(key_waddr), .key_wdata(key_wdata), .key_len_cfg(key_len_cfg),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;
  exp_t sbq[$];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int mkey[KEY_LEN];
  int mkidx = 0;
  int mcfg = 1;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] s2b(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = s[i];
    return r;
  endfunction

  function automatic int eff_len();
    if (mcfg == 0) return 1;
    if (mcfg > KEY_LEN) return KEY_LEN;
    return mcfg;
  endfunction

  // Cipher rules on whole characters: shift within A-Z, a-z, 0-9.
  task automatic model_beat(input logic [31:0] din, input bit last, input bit sh,
                            input bit enc, output logic [31:0] dout);
    int L, n, c, k, base, m;
    L = eff_len();
    n = 0;
    for (int i = 0; i < LANES; i++) begin
      c = int'(din[i*8 +: 8]);
      m = 0;
      base = 0;
      if (c >= "A" && c <= "Z") begin base = "A"; m = 26; end
      else if (c >= "a" && c <= "z") begin base = "a"; m = 26; end
      else if (c >= "0" && c <= "9") begin base = "0"; m = 10; end
      if (sh && m != 0) begin
        k = mkey[(mkidx + n) % L] % m;
        c = base + (enc ? (c - base + k) % m : (c - base + m - k) % m);
        n++;
      end
      dout[i*8 +: 8] = 8'(c);
    end
    if (sh) mkidx = (mkidx + n) % L;
    if (last) mkidx = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    in_valid = 1'b0;
    key_we = 1'b0;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last, input bit sh, input bit enc,
                           input bit use_exp, input logic [31:0] expv, input bit lat,
                           input bit we, input int wa, input int wv);
    bit done;
    bit first;
    logic [31:0] md;
    exp_t e;
    done = 0;
    first = 1;
    for (int t = 0; t < 100 && !done; t++) begin
      tick();
      in_valid = 1'b1; in_data = d; in_last = last; shift_en = sh; mode = enc;
      key_we = first && we; key_waddr = AW'(wa); key_wdata = 5'(wv);
      #1;
      if (in_ready) begin
        model_beat(d, last, sh, enc, md);
        e.data = use_exp ? expv : md;
        e.last = last;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sbq.push_back(e);
        done = 1;
      end
      if (first && we) mkey[wa] = wv % 26;
      first = 0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never seen, expected acceptance");
    end
  endtask

  task automatic write_key(input int a, input int v);
    tick();
    key_we = 1'b1; key_waddr = AW'(a); key_wdata = 5'(v);
    mkey[a] = v % 26;
  endtask

  task automatic set_cfg(input int v);
    tick();
    key_len_cfg = 4'(v);
    mcfg = v;
  endtask

  task automatic drain();
    bit ok;
    rand_rdy = 0;
    ok = 0;
    tick();
    out_ready = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      tick();
      #3;
      if (sbq.size() == 0 && !busy) ok = 1;
    end
    chk("drain_done", ok, 1);
  endtask

  // Monitor: pop and compare on each output transfer; check hold during stalls.
  logic [31:0] prev_d;
  logic prev_l;
  bit stalled = 0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("stall_hold_data", out_data, prev_d);
        chk("stall_hold_last", out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got %0h, expected no beat", out_data);
        end else begin
          e = sbq.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 2);
        end
      end
      stalled = out_valid && !out_ready;
      prev_d = out_data;
      prev_l = out_last;
    end
  end

  function automatic logic [7:0] rchar();
    logic [7:0] edges [8];
    edges = '{8'h40, 8'h5b, 8'h60, 8'h7b, 8'h2f, 8'h3a, 8'h00, 8'hff};
    case ($urandom_range(0, 4))
      0: return 8'(65 + $urandom_range(0, 25));
      1: return 8'(97 + $urandom_range(0, 25));
      2: return 8'(48 + $urandom_range(0, 9));
      3: return 8'($urandom_range(0, 255));
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  initial begin
    logic [31:0] rd;
    for (int i = 0; i < KEY_LEN; i++) mkey[i] = 0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_kidx", dut.kidx, 0);
    @(negedge clk);
    rst = 1'b1;

    // Caesar key 3
    write_key(0, 3);
    set_cfg(1);
    send_beat(s2b("HELL"), 0, 1, 1, 1, s2b("KHOO"), 1, 0, 0, 0);
    drain();
    send_beat(s2b("ABCD"), 0, 1, 0, 1, s2b("XYZA"), 0, 0, 0, 0);
    send_beat(s2b("Z9z0"), 0, 1, 1, 1, s2b("C2c3"), 0, 0, 0, 0);
    send_beat(s2b("C2c3"), 0, 1, 0, 1, s2b("Z9z0"), 0, 0, 0, 0);
    // Same-cycle write uses the old key; the next beat sees the new one
    send_beat(s2b("aaaa"), 0, 1, 1, 1, s2b("dddd"), 0, 1, 0, 5);
    send_beat(s2b("aaaa"), 0, 1, 1, 1, s2b("ffff"), 0, 0, 0, 0);
    drain();

    // Vigenere key {1,2}
    write_key(0, 1);
    write_key(1, 2);
    set_cfg(2);
    send_beat(s2b("ab!c"), 0, 1, 1, 1, s2b("bd!d"), 0, 0, 0, 0);
    drain();
    chk("kidx_after_abc", dut.kidx, 1);
    send_beat(s2b("aaaa"), 0, 1, 1, 1, s2b("cbcb"), 0, 0, 0, 0);
    send_beat(s2b("aaaa"), 1, 1, 1, 1, s2b("cbcb"), 0, 0, 0, 0);
    send_beat(s2b("aaaa"), 0, 1, 1, 1, s2b("bcbc"), 0, 0, 0, 0);
    send_beat(s2b("a!!!"), 0, 1, 1, 1, s2b("b!!!"), 0, 0, 0, 0);
    drain();
    chk("kidx_before_bypass", dut.kidx, 1);
    send_beat(s2b("a1#Z"), 0, 0, 1, 1, s2b("a1#Z"), 0, 0, 0, 0);
    drain();
    chk("kidx_bypass_frozen", dut.kidx, 1);

    // Key value 29 is stored as 3
    write_key(0, 29);
    set_cfg(1);
    tick();
    #1;
    chk("key_mod26", dut.key_tab[0], 3);
    send_beat(s2b("abcd"), 0, 1, 1, 1, s2b("defg"), 0, 0, 0, 0);
    drain();

    // Backpressure: two beats fill the pipe, then in_ready drops
    set_cfg(8);
    for (int i = 0; i < KEY_LEN; i++) write_key(i, $urandom_range(0, 31));
    tick();
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) rd[i*8 +: 8] = rchar();
      send_beat(rd, 0, 1, 1, 0, '0, 0, 0, 0, 0);
    end
    for (int s = 0; s < 3; s++) begin
      tick();
      #1;
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) rd[i*8 +: 8] = rchar();
      send_beat(rd, b == 1, 1, 0, 0, '0, 0, 0, 0, 0);
    end
    drain();

    // Randomized traffic with random backpressure and key updates
    rand_rdy = 1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        drain();
        set_cfg($urandom_range(0, 15));
        rand_rdy = 1;
      end else begin
        for (int i = 0; i < 4; i++) rd[i*8 +: 8] = rchar();
        send_beat(rd, $urandom_range(0, 5) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1), 0, '0, 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, KEY_LEN-1),
                  $urandom_range(0, 31));
      end
    end
    drain();

    // Reset with beats in flight
    set_cfg(3);
    write_key(1, 7);
    tick();
    out_ready = 1'b0;
    send_beat(s2b("zzzz"), 0, 1, 1, 0, '0, 0, 0, 0, 0);
    send_beat(s2b("yyyy"), 0, 1, 1, 0, '0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_kidx", dut.kidx, 0);
    for (int i = 0; i < KEY_LEN; i++) chk("midrst_key", dut.key_tab[i], 0);
    sbq.delete();
    for (int i = 0; i < KEY_LEN; i++) mkey[i] = 0;
    mkidx = 0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    #1;
    chk("post_rst_no_valid", out_valid, 0);
    send_beat(s2b("abcd"), 0, 1, 1, 1, s2b("abcd"), 1, 0, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
